stride_count_ctrl: RTL and testbench

//  Sequencer for the programmable arithmetic counter datapath: holds start/stride/limit

---
 rtl/stride_count_ctrl.sv | 130 +++++++++++++
 tb/tb_stride_count_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/stride_count_ctrl.sv
// Programmable arithmetic sequence controller: holds start/stride/limit/wrap config and
// steps Count from start by stride up to limit, with pause, abort, wrap and one-shot Done.
module stride_count_ctrl #(
  parameter int WIDTH          = 32,
  parameter int DEFAULT_START  = 1,
  parameter int DEFAULT_STRIDE = 2
) (
  input  logic             Clk,
  input  logic             Rst_l,
  input  logic             Cfg_valid,
  output logic             Cfg_ready,
  input  logic [WIDTH-1:0] Cfg_start,
  input  logic [WIDTH-1:0] Cfg_stride,
  input  logic [WIDTH-1:0] Cfg_limit,
  input  logic             Cfg_wrap,
  input  logic             Go,
  input  logic             Pause,
  input  logic             Abort,
  output logic [WIDTH-1:0] Count,
  output logic             Count_valid,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

  localparam logic [WIDTH-1:0] START_INIT  = WIDTH'(DEFAULT_START);
  localparam logic [WIDTH-1:0] STRIDE_INIT = WIDTH'(DEFAULT_STRIDE);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_start, r_stride, r_limit, r_count, w_count_nxt;
  logic             r_wrap, r_done, r_ovf, w_done_nxt, w_ovf_nxt;
  logic             r_count_valid, r_busy, r_cfg_ready;
  logic [WIDTH:0]   w_sum;
  logic             w_terminal, w_cfg_acc;

  // One extra bit on the sum catches the carry out of WIDTH bits as a terminal condition.
  assign w_sum      = {1'b0, r_count} + {1'b0, r_stride};
  assign w_terminal = w_sum[WIDTH] || (w_sum > {1'b0, r_limit});
  assign w_cfg_acc  = Cfg_valid && (r_state == ST_IDLE) && !Abort;

  // NOTE: every signal gets a hold/default value first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    w_ovf_nxt   = r_ovf;
    if (Abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_cfg_acc) begin
            w_count_nxt = Cfg_start;
          end else if (Go) begin
            w_count_nxt = r_start;
            if (r_start <= r_limit) begin
              w_state_nxt = ST_RUN;
              w_ovf_nxt   = 1'b0;
            end else begin
              w_done_nxt = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (Pause) begin
            w_state_nxt = ST_PAUSE;
          end else if (!w_terminal) begin
            w_count_nxt = w_sum[WIDTH-1:0];
          end else begin
            if (w_sum[WIDTH]) w_ovf_nxt = 1'b1;
            if (r_wrap) begin
              w_count_nxt = r_start;
            end else begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (!Pause) w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together
  // from the values present before the edge.
  always_ff @(posedge Clk or negedge Rst_l) begin
    if (!Rst_l) begin
      r_state       <= ST_IDLE;
      r_start       <= START_INIT;
      r_stride      <= STRIDE_INIT;
      r_limit       <= '1;
      r_wrap        <= 1'b0;
      r_count       <= START_INIT;
      r_done        <= 1'b0;
      r_ovf         <= 1'b0;
      r_count_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_cfg_ready   <= 1'b1;
    end else begin
      if (w_cfg_acc) begin
        r_start  <= Cfg_start;
        r_stride <= Cfg_stride;
        r_limit  <= Cfg_limit;
        r_wrap   <= Cfg_wrap;
      end
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_done        <= w_done_nxt;
      r_ovf         <= w_ovf_nxt;
      // Status flags are flopped from the next state so they leave the block straight from flops.
      r_count_valid <= (w_state_nxt == ST_RUN);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_cfg_ready   <= (w_state_nxt == ST_IDLE);
    end
  end

  assign Cfg_ready   = r_cfg_ready;
  assign Count       = r_count;
  assign Count_valid = r_count_valid;
  assign Busy        = r_busy;
  assign Done        = r_done;
  assign Overflow    = r_ovf;

endmodule

// File: tb/tb_stride_count_ctrl.sv
// Directed bench for stride_count_ctrl: a 32-bit instance for sequencing/control and an
// 8-bit instance for carry-out overflow cases.
module tb_stride_count_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_l;
  logic        cfg_valid, cfg_wrap, go, pause, abort;
  logic [31:0] cfg_start, cfg_stride, cfg_limit;
  logic        cfg_ready, count_valid, busy, done, ovf;
  logic [31:0] count;

  logic        e8_cfg_valid, e8_cfg_wrap, e8_go, e8_pause, e8_abort;
  logic [7:0]  e8_cfg_start, e8_cfg_stride, e8_cfg_limit;
  logic        e8_cfg_ready, e8_count_valid, e8_busy, e8_done, e8_ovf;
  logic [7:0]  e8_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  stride_count_ctrl dut (
    .Clk(Clk), .Rst_l(Rst_l), .Cfg_valid(cfg_valid), .Cfg_ready(cfg_ready),
    .Cfg_start(cfg_start), .Cfg_stride(cfg_stride), .Cfg_limit(cfg_limit), .Cfg_wrap(cfg_wrap),
    .Go(go), .Pause(pause), .Abort(abort), .Count(count), .Count_valid(count_valid),
    .Busy(busy), .Done(done), .Overflow(ovf)
  );

  stride_count_ctrl #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Rst_l(Rst_l), .Cfg_valid(e8_cfg_valid), .Cfg_ready(e8_cfg_ready),
    .Cfg_start(e8_cfg_start), .Cfg_stride(e8_cfg_stride), .Cfg_limit(e8_cfg_limit),
    .Cfg_wrap(e8_cfg_wrap), .Go(e8_go), .Pause(e8_pause), .Abort(e8_abort), .Count(e8_count),
    .Count_valid(e8_count_valid), .Busy(e8_busy), .Done(e8_done), .Overflow(e8_ovf)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic cfg32(input logic [31:0] s, input logic [31:0] st, input logic [31:0] l, input logic w);
    cfg_valid = 1'b1; cfg_start = s; cfg_stride = st; cfg_limit = l; cfg_wrap = w;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic go32();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic abort32();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic cfg8(input logic [7:0] s, input logic [7:0] st, input logic [7:0] l, input logic w);
    e8_cfg_valid = 1'b1; e8_cfg_start = s; e8_cfg_stride = st; e8_cfg_limit = l; e8_cfg_wrap = w;
    tick();
    e8_cfg_valid = 1'b0;
  endtask

  task automatic go8();
    e8_go = 1'b1;
    tick();
    e8_go = 1'b0;
  endtask

  task automatic test_reset();
    Rst_l = 1'b0;
    cfg_valid = 0; cfg_wrap = 0; go = 0; pause = 0; abort = 0;
    cfg_start = 0; cfg_stride = 0; cfg_limit = 0;
    e8_cfg_valid = 0; e8_cfg_wrap = 0; e8_go = 0; e8_pause = 0; e8_abort = 0;
    e8_cfg_start = 0; e8_cfg_stride = 0; e8_cfg_limit = 0;
    tick(); tick();
    Rst_l = 1'b1;
    tick();
    n_cmp++; if (count !== 32'd1) begin n_err++; $display("FAIL reset_count: got %0d want 1", count); end
    n_cmp++; if ({count_valid, busy, done, ovf} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {count_valid, busy, done, ovf}); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
  endtask

  task automatic test_default_seq();
    cfg32(32'd1, 32'd2, 32'd9, 1'b0);
    go32();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({count_valid, count} !== {1'b1, 32'(1 + 2 * i)}) begin n_err++; $display("FAIL seq_value[%0d]: got valid=%b count=%0d want valid=1 count=%0d", i, count_valid, count, 1 + 2 * i); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL seq_no_done[%0d]: got %b want 0", i, done); end
      if (i < 4) tick();
    end
    tick();
    n_cmp++; if ({done, count_valid, busy, count} !== {3'b100, 32'd9}) begin n_err++; $display("FAIL seq_done: got done=%b valid=%b busy=%b count=%0d want 1,0,0,9", done, count_valid, busy, count); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL seq_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_pause();
    go32();
    tick(); tick();
    n_cmp++; if (count !== 32'd5) begin n_err++; $display("FAIL pause_pre: got %0d want 5", count); end
    pause = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if ({count_valid, busy, count} !== {2'b01, 32'd5}) begin n_err++; $display("FAIL pause_hold[%0d]: got valid=%b busy=%b count=%0d want 0,1,5", i, count_valid, busy, count); end
    end
    pause = 1'b0;
    tick();
    n_cmp++; if ({count_valid, count} !== {1'b1, 32'd5}) begin n_err++; $display("FAIL pause_resume: got valid=%b count=%0d want 1,5", count_valid, count); end
    tick();
    n_cmp++; if (count !== 32'd7) begin n_err++; $display("FAIL pause_next: got %0d want 7", count); end
    abort32();
    n_cmp++; if ({busy, count_valid, done, count} !== {3'b000, 32'd7}) begin n_err++; $display("FAIL abort_run: got busy=%b valid=%b done=%b count=%0d want 0,0,0,7", busy, count_valid, done, count); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b want 1", cfg_ready); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_seq [7] = '{32'd0, 32'd3, 32'd6, 32'd9, 32'd0, 32'd3, 32'd6};
    cfg32(32'd0, 32'd3, 32'd10, 1'b1);
    go32();
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if ({count_valid, done, count} !== {2'b10, exp_seq[i]}) begin n_err++; $display("FAIL wrap[%0d]: got valid=%b done=%b count=%0d want 1,0,%0d", i, count_valid, done, count, exp_seq[i]); end
      if (i < 6) tick();
    end
    abort32();
    n_cmp++; if ({busy, done, count} !== {2'b00, 32'd6}) begin n_err++; $display("FAIL wrap_abort: got busy=%b done=%b count=%0d want 0,0,6", busy, done, count); end
  endtask

  task automatic test_start_gt_limit();
    cfg32(32'd12, 32'd1, 32'd10, 1'b0);
    n_cmp++; if (count !== 32'd12) begin n_err++; $display("FAIL cfg_count_load: got %0d want 12", count); end
    go32();
    n_cmp++; if ({done, busy, count_valid} !== 3'b100) begin n_err++; $display("FAIL empty_go: got done=%b busy=%b valid=%b want 1,0,0", done, busy, count_valid); end
    tick();
    n_cmp++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL empty_go_after: got done=%b busy=%b want 0,0", done, busy); end
  endtask

  task automatic test_cfg_priority();
    cfg_valid = 1'b1; cfg_start = 32'd4; cfg_stride = 32'd1; cfg_limit = 32'd20; cfg_wrap = 1'b0;
    go = 1'b1;
    tick();
    cfg_valid = 1'b0; go = 1'b0;
    n_cmp++; if ({busy, count_valid, count} !== {2'b00, 32'd4}) begin n_err++; $display("FAIL cfg_go_same: got busy=%b valid=%b count=%0d want 0,0,4", busy, count_valid, count); end
    go32();
    n_cmp++; if ({count_valid, cfg_ready, count} !== {2'b10, 32'd4}) begin n_err++; $display("FAIL run_start: got valid=%b ready=%b count=%0d want 1,0,4", count_valid, cfg_ready, count); end
    cfg_valid = 1'b1; cfg_start = 32'd100; cfg_stride = 32'd50;
    tick(); tick();
    cfg_valid = 1'b0;
    n_cmp++; if (count !== 32'd6) begin n_err++; $display("FAIL cfg_in_run: got %0d want 6", count); end
    abort32();
    go32();
    n_cmp++; if (count !== 32'd4) begin n_err++; $display("FAIL cfg_not_taken: got %0d want 4", count); end
    abort32();
  endtask

  task automatic test_overflow8();
    cfg8(8'd250, 8'd5, 8'd254, 1'b0);
    go8();
    n_cmp++; if ({e8_count_valid, e8_count} !== {1'b1, 8'd250}) begin n_err++; $display("FAIL ov_a_first: got valid=%b count=%0d want 1,250", e8_count_valid, e8_count); end
    tick();
    n_cmp++; if ({e8_done, e8_ovf, e8_count} !== {2'b10, 8'd250}) begin n_err++; $display("FAIL ov_a_done: got done=%b ovf=%b count=%0d want 1,0,250", e8_done, e8_ovf, e8_count); end
    cfg8(8'd250, 8'd7, 8'd255, 1'b0);
    go8();
    n_cmp++; if (e8_count !== 8'd250) begin n_err++; $display("FAIL ov_b_first: got %0d want 250", e8_count); end
    tick();
    n_cmp++; if ({e8_done, e8_ovf, e8_busy, e8_count} !== {3'b110, 8'd250}) begin n_err++; $display("FAIL ov_b_done: got done=%b ovf=%b busy=%b count=%0d want 1,1,0,250", e8_done, e8_ovf, e8_busy, e8_count); end
    tick();
    n_cmp++; if ({e8_done, e8_ovf} !== 2'b01) begin n_err++; $display("FAIL ov_sticky: got done=%b ovf=%b want 0,1", e8_done, e8_ovf); end
    cfg8(8'd250, 8'd5, 8'd255, 1'b0);
    go8();
    n_cmp++; if ({e8_ovf, e8_count_valid, e8_count} !== {2'b01, 8'd250}) begin n_err++; $display("FAIL ov_c_first: got ovf=%b valid=%b count=%0d want 0,1,250", e8_ovf, e8_count_valid, e8_count); end
    tick();
    n_cmp++; if ({e8_count_valid, e8_done, e8_count} !== {2'b10, 8'd255}) begin n_err++; $display("FAIL ov_c_second: got valid=%b done=%b count=%0d want 1,0,255", e8_count_valid, e8_done, e8_count); end
    tick();
    n_cmp++; if ({e8_done, e8_count_valid, e8_count} !== {2'b10, 8'd255}) begin n_err++; $display("FAIL ov_c_done: got done=%b valid=%b count=%0d want 1,0,255", e8_done, e8_count_valid, e8_count); end
  endtask

  task automatic test_reset_mid();
    cfg32(32'd0, 32'd3, 32'd10, 1'b1);
    go32();
    tick();
    Rst_l = 1'b0;
    #1;
    n_cmp++; if ({busy, count_valid, count} !== {2'b00, 32'd1}) begin n_err++; $display("FAIL rst_mid: got busy=%b valid=%b count=%0d want 0,0,1", busy, count_valid, count); end
    tick();
    Rst_l = 1'b1;
    tick();
    go32();
    tick();
    n_cmp++; if ({count_valid, count} !== {1'b1, 32'd3}) begin n_err++; $display("FAIL rst_defaults: got valid=%b count=%0d want 1,3", count_valid, count); end
    abort32();
  endtask

  initial begin
    test_reset();
    test_default_seq();
    test_pause();
    test_wrap();
    test_start_gt_limit();
    test_cfg_priority();
    test_overflow8();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
